// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
// The optional access timeout is enabled by the MEM_ARB_TIMEOUT_EN macro.
package mem_arb_pkg;

  localparam int ADDR_W_DEF      = 5;
  localparam int DATA_W_DEF      = 8;
  localparam int TIMEOUT_CYC_DEF = 15;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arbState_e;

  typedef logic reqId_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
// The slave view belongs to the arbiter; the master view is the surrounding system.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              err;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  mem_ready, mem_rdata,
    output ack0, ack1, rdata, err,
    output mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output mem_ready, mem_rdata,
    input  ack0, ack1, rdata, err,
    input  mem_rd, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester not served last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  reqId_t last_grant,
  output logic   gnt_valid,
  output reqId_t gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = 1'b0;
    if (req0 && req1) begin
      gnt_id = ~last_grant;
    end else if (req1) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter serialising requests onto the single data-memory port.
// Define MEM_ARB_TIMEOUT_EN to abort accesses that never see mem_ready (reported on err).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  arbState_e         state;
  arbState_e         stateNext;
  reqId_t            lastGrant;
  reqId_t            winner;
  reqId_t            gntId;
  logic              gntValid;
  logic              latchCmd;
  logic              firstCycle;
  logic              readySeen;
  logic              timedOut;

  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic              cmdWe;
  logic [ADDR_W-1:0] cmdAddr;
  logic [DATA_W-1:0] cmdWdata;

  logic              memRdQ;
  logic              memWrQ;
  logic              memRdNext;
  logic              memWrNext;
  logic [1:0]        ackQ;
  logic [1:0]        ackNext;
  logic              errQ;
  logic              errNext;
  logic [DATA_W-1:0] rdataQ;
  logic [DATA_W-1:0] rdataNext;

  rr_pick2 picker (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (lastGrant),
    .gnt_valid  (gntValid),
    .gnt_id     (gntId)
  );

  assign selWe    = gntId ? bus.we1    : bus.we0;
  assign selAddr  = gntId ? bus.addr1  : bus.addr0;
  assign selWdata = gntId ? bus.wdata1 : bus.wdata0;

  // The first ACCESS cycle still shows ready left over from the previous access.
  assign readySeen = !firstCycle && bus.mem_ready;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] toCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toCnt <= '0;
    end else if (state == ACCESS) begin
      toCnt <= toCnt + CNT_W'(1);
    end else begin
      toCnt <= '0;
    end
  end

  assign timedOut = (state == ACCESS) && !readySeen
                    && (toCnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timedOut = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state plus the next value of every registered output.
  always_comb begin
    stateNext = state;
    latchCmd  = 1'b0;
    memRdNext = 1'b0;
    memWrNext = 1'b0;
    ackNext   = 2'b00;
    errNext   = 1'b0;
    rdataNext = rdataQ;
    case (state)
      IDLE: begin
        if (gntValid) begin
          stateNext = ACCESS;
          latchCmd  = 1'b1;
          memRdNext = !selWe;
          memWrNext = selWe;
        end
      end
      ACCESS: begin
        memRdNext = !cmdWe;
        memWrNext = cmdWe;
        if (readySeen) begin
          stateNext       = RESP;
          memRdNext       = 1'b0;
          memWrNext       = 1'b0;
          ackNext[winner] = 1'b1;
          rdataNext       = cmdWe ? '0 : bus.mem_rdata;
        end else if (timedOut) begin
          stateNext       = RESP;
          memRdNext       = 1'b0;
          memWrNext       = 1'b0;
          ackNext[winner] = 1'b1;
          errNext         = 1'b1;
          rdataNext       = '0;
        end
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGrant  <= 1'b1;
      winner     <= 1'b0;
      cmdWe      <= 1'b0;
      cmdAddr    <= '0;
      cmdWdata   <= '0;
      firstCycle <= 1'b0;
      memRdQ     <= 1'b0;
      memWrQ     <= 1'b0;
      ackQ       <= 2'b00;
      errQ       <= 1'b0;
      rdataQ     <= '0;
    end else begin
      if (latchCmd) begin
        lastGrant <= gntId;
        winner    <= gntId;
        cmdWe     <= selWe;
        cmdAddr   <= selAddr;
        cmdWdata  <= selWdata;
      end
      firstCycle <= latchCmd;
      memRdQ     <= memRdNext;
      memWrQ     <= memWrNext;
      ackQ       <= ackNext;
      errQ       <= errNext;
      rdataQ     <= rdataNext;
    end
  end

  assign bus.mem_rd    = memRdQ;
  assign bus.mem_wr    = memWrQ;
  assign bus.mem_addr  = cmdAddr;
  assign bus.mem_wdata = cmdWdata;
  assign bus.ack0      = ackQ[0];
  assign bus.ack1      = ackQ[1];
  assign bus.err       = errQ;
  assign bus.rdata     = rdataQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a 32x8 memory model whose ready delay is programmable.
// Covers both builds; the no-ready case expects a timeout only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  typedef struct packed {
    logic       id;
    logic [7:0] rdata;
    logic       err;
  } expAck_t;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [32];
  int         readyAfter = 1;
  int         stbCnt     = 0;
  int         cyc        = 0;
  int         ackCount   = 0;
  int         lastAckCyc = 0;
  int         rdHigh     = 0;
  int         wrHigh     = 0;
  int         reqCyc     = 0;
  int         ackBase    = 0;
  int         rdBase     = 0;
  int         wrBase     = 0;
  int         errors     = 0;
  int         checks     = 0;
  logic       prevAck    = 1'b0;
  expAck_t    expQ[$];
  expAck_t    expItem;

  // Memory model: reset restores the preload, writes land when the arbiter sees ready.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      mem[3] <= 8'h5A;
      mem[5] <= 8'h11;
      mem[6] <= 8'h22;
    end else if (bus.mem_wr && bus.mem_ready) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.mem_ready = (bus.mem_rd || bus.mem_wr) && (stbCnt >= readyAfter);

  always @(posedge clk) begin
    stbCnt <= (bus.mem_rd || bus.mem_wr) ? stbCnt + 1 : 0;
    cyc    <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Ack monitor: pops the scoreboard on every ack and checks pulse shape.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_rd) rdHigh <= rdHigh + 1;
      if (bus.mem_wr) wrHigh <= wrHigh + 1;
      checkOutput("dualAck", 32'(bus.ack0 & bus.ack1), 0);
      if (bus.ack0 || bus.ack1) begin
        checkOutput("ackPulse", 32'(prevAck), 0);
        checkOutput("ackQueued", 32'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          expItem = expQ.pop_front();
          checkOutput("ackId", 32'(bus.ack1), 32'(expItem.id));
          checkOutput("rdata", 32'(bus.rdata), 32'(expItem.rdata));
          checkOutput("err", 32'(bus.err), 32'(expItem.err));
        end
        ackCount   <= ackCount + 1;
        lastAckCyc <= cyc;
      end
      prevAck <= bus.ack0 || bus.ack1;
    end else begin
      prevAck <= 1'b0;
    end
  end

  task automatic applyStimulus(input logic id, input logic we, input logic [4:0] addr,
                               input logic [7:0] wdata, input logic [7:0] expRdata,
                               input logic expErr, input int ready);
    @(negedge clk);
    #1;
    readyAfter = ready;
    if (id) begin
      bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
    end else begin
      bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
    end
    expQ.push_back(expAck_t'{id, expRdata, expErr});
    reqCyc  = cyc;
    ackBase = ackCount;
    rdBase  = rdHigh;
    wrBase  = wrHigh;
  endtask

  task automatic waitAck(input int target, input int budget);
    int n = 0;
    while (ackCount < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("ackArrived", 32'(ackCount >= target), 1);
  endtask

  initial begin
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rstAck0", 32'(bus.ack0), 0);
    checkOutput("rstAck1", 32'(bus.ack1), 0);
    checkOutput("rstErr", 32'(bus.err), 0);
    checkOutput("rstMemRd", 32'(bus.mem_rd), 0);
    checkOutput("rstMemWr", 32'(bus.mem_wr), 0);
    checkOutput("rstMemAddr", 32'(bus.mem_addr), 0);
    checkOutput("rstMemWdata", 32'(bus.mem_wdata), 0);
    checkOutput("rstRdata", 32'(bus.rdata), 0);
    rst = 1'b0;

    $display("[TB] minimum-latency read by requester 0");
    applyStimulus(1'b0, 1'b0, 5'd3, 8'h00, 8'h5A, 1'b0, 1);
    waitAck(ackBase + 1, 20);
    bus.req0 = 1'b0;
    checkOutput("readLatency", 32'(lastAckCyc - reqCyc), 3);
    checkOutput("readRdCycles", 32'(rdHigh - rdBase), 2);

    $display("[TB] write by requester 1 then readback");
    applyStimulus(1'b1, 1'b1, 5'd31, 8'hC3, 8'h00, 1'b0, 1);
    @(negedge clk);
    #1;
    checkOutput("wrStrobe", 32'(bus.mem_wr), 1);
    checkOutput("wrNoRd", 32'(bus.mem_rd), 0);
    checkOutput("wrAddr", 32'(bus.mem_addr), 31);
    checkOutput("wrData", 32'(bus.mem_wdata), 32'hC3);
    waitAck(ackBase + 1, 20);
    bus.req1 = 1'b0;
    checkOutput("writeLatency", 32'(lastAckCyc - reqCyc), 3);
    checkOutput("writeWrCycles", 32'(wrHigh - wrBase), 2);
    applyStimulus(1'b1, 1'b0, 5'd31, 8'h00, 8'hC3, 1'b0, 0);
    waitAck(ackBase + 1, 20);
    bus.req1 = 1'b0;
    checkOutput("staleReadyLatency", 32'(lastAckCyc - reqCyc), 3);

    $display("[TB] continuous contention");
    @(negedge clk);
    #1;
    readyAfter = 1;
    bus.we0 = 1'b0; bus.addr0 = 5'd5;
    bus.we1 = 1'b0; bus.addr1 = 5'd6;
    for (int i = 0; i < 2; i++) begin
      expQ.push_back(expAck_t'{1'b0, 8'h11, 1'b0});
      expQ.push_back(expAck_t'{1'b1, 8'h22, 1'b0});
    end
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    reqCyc  = cyc;
    ackBase = ackCount;
    waitAck(ackBase + 4, 60);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    checkOutput("contentionSpan", 32'(lastAckCyc - reqCyc), 15);

    $display("[TB] slow memory, request dropped after grant");
    applyStimulus(1'b0, 1'b0, 5'd5, 8'h00, 8'h11, 1'b0, 6);
    @(negedge clk);
    #1;
    bus.req0 = 1'b0;
    waitAck(ackBase + 1, 30);
    checkOutput("slowLatency", 32'(lastAckCyc - reqCyc), 8);
    checkOutput("slowRdCycles", 32'(rdHigh - rdBase), 7);

    $display("[TB] memory never ready");
`ifdef MEM_ARB_TIMEOUT_EN
    applyStimulus(1'b0, 1'b0, 5'd5, 8'h00, 8'h00, 1'b1, 1000);
    waitAck(ackBase + 1, 40);
    bus.req0 = 1'b0;
    checkOutput("timeoutLatency", 32'(lastAckCyc - reqCyc), 16);
    applyStimulus(1'b0, 1'b0, 5'd5, 8'h00, 8'h11, 1'b0, 1000);
    repeat (3) @(negedge clk);
    #1;
`else
    applyStimulus(1'b0, 1'b0, 5'd5, 8'h00, 8'h11, 1'b0, 1000);
    repeat (100) @(negedge clk);
    #1;
    checkOutput("noAckWithoutReady", 32'(ackCount - ackBase), 0);
`endif
    checkOutput("rdHeldInAccess", 32'(bus.mem_rd), 1);

    $display("[TB] reset during access");
    rst = 1'b1;
    #1;
    checkOutput("asyncRdDrop", 32'(bus.mem_rd), 0);
    checkOutput("asyncWrDrop", 32'(bus.mem_wr), 0);
    expQ.delete();
    bus.req0   = 1'b0;
    ackBase    = ackCount;
    readyAfter = 1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("noAckAfterReset", 32'(ackCount - ackBase), 0);
    rst = 1'b0;

    bus.we0 = 1'b0; bus.addr0 = 5'd5;
    bus.we1 = 1'b0; bus.addr1 = 5'd6;
    expQ.push_back(expAck_t'{1'b0, 8'h11, 1'b0});
    expQ.push_back(expAck_t'{1'b1, 8'h22, 1'b0});
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    reqCyc  = cyc;
    ackBase = ackCount;
    waitAck(ackBase + 2, 30);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    checkOutput("tieSpan", 32'(lastAckCyc - reqCyc), 7);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("queueDrained", 32'(expQ.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
